hpdcache_req_issuer: RTL
========================

Name: hpdcache_req_issuer

Overview:
- Requester-side initiator for one HPDcache core request port; it drives the interface that the core request arbiter receives.
- Takes requests from a client and issues them with the two-cycle protocol: request in the 1st cycle, abort/tag/PMA in the 2nd cycle.
- Allocates transaction IDs from a local pool and retires them when the matching response returns. Responses carrying another SID are ignored.
- Sits between a client (load/store unit, prefetcher, accelerator) and one requester slot of the arbiter.

Parameters:
- SID, 0: requester ID written into every issued request's sid field; responses are filtered on it.
- NTRANS, 4: number of outstanding need_rsp transactions; legal range 1 to 2^HPDCACHE_REQ_TRANS_ID_WIDTH.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- up_req_valid_i  in  1  client request valid
- up_req_ready_o  out  1  client request accepted
- up_req_i  in  $bits(hpdcache_req_t)  client request; sid/tid fields are ignored
- up_abort_i  in  1  abort of the client's last granted request, sampled the cycle after grant
- up_tag_i  in  $bits(hpdcache_tag_t)  tag, captured with the request
- up_pma_i  in  $bits(hpdcache_pma_t)  PMA, captured with the request
- core_req_valid_o  out  1  request valid to the cache/arbiter
- core_req_ready_i  in  1  grant from the cache/arbiter
- core_req_o  out  $bits(hpdcache_req_t)  request with sid=SID and allocated tid
- core_req_abort_o  out  1  2nd-cycle abort
- core_req_tag_o  out  $bits(hpdcache_tag_t)  2nd-cycle tag
- core_req_pma_o  out  $bits(hpdcache_pma_t)  2nd-cycle PMA
- core_rsp_valid_i  in  1  response valid
- core_rsp_i  in  $bits(hpdcache_rsp_t)  response
- up_rsp_valid_o  out  1  filtered response valid to the client
- up_rsp_o  out  $bits(hpdcache_rsp_t)  response to the client
- outstanding_o  out  $clog2(NTRANS+1)  number of busy TIDs
- spurious_rsp_o  out  1  one-cycle pulse on an own-SID response to a free TID

Behaviour:
- Reset values:
  - core_req_valid_o=0, core_req_abort_o=0, spurious_rsp_o=0, outstanding_o=0.
  - All TIDs free; request, tag and PMA registers cleared to 0.
- Stage 0 (request register), registered output:
  - up_req_ready_o = (!core_req_valid_o | core_req_ready_i) & (!up_req_i.need_rsp | tid_avail).
  - On an up handshake at edge E, the register loads up_req_i with sid=SID. tid = lowest-index free TID if need_rsp, else 0.
  - core_req_valid_o=1 from E; issue latency is 1 cycle.
  - Once asserted, core_req_valid_o and core_req_o stay stable until core_req_ready_i.
  - Back-to-back issue at full throughput when the cache is always ready.
- Tag/PMA staging:
  - up_tag_i/up_pma_i are captured at the up handshake into a pending register.
  - They move to a 2nd-cycle register on grant (core_req_valid_o & core_req_ready_i at cycle T).
  - core_req_tag_o/core_req_pma_o hold that value in cycle T+1 and stay until the next grant, so a new request loaded at the grant edge cannot corrupt them.
- Abort: core_req_abort_o = up_abort_i & granted_q, where granted_q=1 only in the cycle after a grant; 0 otherwise.
- TID pool:
  - Busy bit set at the up handshake when need_rsp=1.
  - Busy bit cleared when core_rsp_valid_i & core_rsp_i.sid==SID & busy[core_rsp_i.tid].
  - Aborted requests are still retired by their response.
  - Same-cycle allocate and free: both apply. Allocation picks only from currently-free entries, so the freed TID becomes reusable next cycle.
  - When all NTRANS are busy, need_rsp requests stall; need_rsp=0 requests still flow.
  - outstanding_o = popcount(busy), registered.
- Responses:
  - up_rsp_valid_o = core_rsp_valid_i & (core_rsp_i.sid==SID), combinational; up_rsp_o = core_rsp_i.
  - There is no response backpressure: the client must always accept.
  - An own-SID response whose TID is free, or whose tid >= NTRANS: forwarded anyway, spurious_rsp_o pulses for one cycle, no state change.
- Reset mid-operation clears all state asynchronously; in-flight responses are then treated as spurious.

Decomposition:
- hpdcache_pkg is unchanged. It already provides hpdcache_req_t, hpdcache_rsp_t, hpdcache_tag_t, hpdcache_pma_t and HPDCACHE_REQ_TRANS_ID_WIDTH.
- Sub-module hpdcache_tid_pool holds the busy vector, the lowest-free priority encoder, tid_avail, the free/spurious logic and the popcount.

Test Plan:
- Issue with cache always ready, SID=2, NTRANS=4, four need_rsp loads → tids 0,1,2,3 issued on consecutive cycles; tag/PMA each one cycle after its grant; outstanding_o=4; fifth load stalls with up_req_ready_o=0.
- Response with sid=2, tid=1 while all four are busy → up_rsp_valid_o=1; outstanding_o=3; the stalled load is issued with tid=1.
- core_req_ready_i held low for 5 cycles → core_req_o/valid stable; tag/PMA outputs unchanged until the grant.
- up_abort_i=1 in the cycle after the grant of tid=0 → core_req_abort_o=1 for exactly that cycle; tid 0 stays busy until its response.
- Response with sid=3 → up_rsp_valid_o=0, no TID change. Response with sid=2 to a free tid → spurious_rsp_o pulses once.
- Same-cycle response freeing tid=0 while a new need_rsp request is accepted with tid 1 free → new tid=1; next request gets tid=0. Then assert rst_ni low mid-burst → all outputs reach reset values immediately.

Source files
------------

// File: rtl/hpdcache_pkg.sv
// Shared HPDcache request/response types used by the core-side request ports.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hpdcache_pkg;

    localparam int unsigned HPDCACHE_REQ_TRANS_ID_WIDTH = 6;
    localparam int unsigned HPDCACHE_REQ_SRC_ID_WIDTH   = 3;
    localparam int unsigned HPDCACHE_TAG_WIDTH          = 20;

    typedef logic [HPDCACHE_REQ_TRANS_ID_WIDTH-1:0] hpdcache_req_tid_t;
    typedef logic [HPDCACHE_REQ_SRC_ID_WIDTH-1:0]   hpdcache_req_sid_t;
    typedef logic [HPDCACHE_TAG_WIDTH-1:0]          hpdcache_tag_t;

    typedef struct packed {
        logic uncacheable;
        logic io;
    } hpdcache_pma_t;

    typedef struct packed {
        logic [11:0]       addr_offset;
        logic [31:0]       wdata;
        logic [3:0]        op;
        logic [3:0]        be;
        logic [2:0]        size;
        hpdcache_req_sid_t sid;
        hpdcache_req_tid_t tid;
        logic              need_rsp;
        logic              phys_indexed;
    } hpdcache_req_t;

    typedef struct packed {
        logic [31:0]       rdata;
        hpdcache_req_sid_t sid;
        hpdcache_req_tid_t tid;
        logic              error;
        logic              aborted;
    } hpdcache_rsp_t;

endpackage

// File: rtl/hpdcache_tid_pool.sv
// Transaction-ID pool: lowest-free allocation, retirement on own responses, busy count.
// Latency: allocation visible next cycle; freed TIDs become allocatable next cycle.
// Backpressure: tid_avail_o low when every TID is busy; the caller must not allocate then.
//
// Ports: alloc_i claims alloc_tid_o this cycle; rsp_own_i/rsp_tid_i present an
// own-SID response; spurious_o flags one that matches no busy TID;
// outstanding_o is the popcount of the busy vector.
module hpdcache_tid_pool
    import hpdcache_pkg::*;
#(
    parameter int unsigned NTRANS = 4
)(
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            alloc_i,
    output logic                            tid_avail_o,
    output hpdcache_req_tid_t               alloc_tid_o,
    input  logic                            rsp_own_i,
    input  hpdcache_req_tid_t               rsp_tid_i,
    output logic                            spurious_o,
    output logic [$clog2(NTRANS+1)-1:0]     outstanding_o
);

    localparam int unsigned CNT_W = $clog2(NTRANS + 1);

    logic [NTRANS-1:0] busy_q;
    logic [NTRANS-1:0] busy_d;
    logic [NTRANS-1:0] alloc_vec;
    logic [NTRANS-1:0] hit_vec;
    logic [NTRANS-1:0] free_vec;
    logic [CNT_W-1:0]  cnt;

    // Downward scan so the last write wins with the lowest free index.
    always_comb begin
        alloc_tid_o = '0;
        for (int i = int'(NTRANS) - 1; i >= 0; i--) begin
            if (!busy_q[i]) alloc_tid_o = hpdcache_req_tid_t'(i);
        end
    end

    // Response TIDs beyond the pool match nothing, which makes them spurious
    // without ever indexing busy_q out of range.
    always_comb begin
        alloc_vec = '0;
        hit_vec   = '0;
        for (int i = 0; i < int'(NTRANS); i++) begin
            alloc_vec[i] = alloc_i & !busy_q[i] & (alloc_tid_o == hpdcache_req_tid_t'(i));
            hit_vec[i]   = (rsp_tid_i == hpdcache_req_tid_t'(i));
        end
    end

    assign free_vec    = {NTRANS{rsp_own_i}} & hit_vec & busy_q;
    assign spurious_o  = rsp_own_i & ~|(hit_vec & busy_q);
    assign tid_avail_o = ~&busy_q;

    // Allocation only targets entries free before this edge, so set and
    // clear never collide on the same bit.
    assign busy_d = (busy_q & ~free_vec) | alloc_vec;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < int'(NTRANS); i++) begin
            cnt = cnt + CNT_W'(busy_q[i]);
        end
    end

    assign outstanding_o = cnt;

endmodule

// File: rtl/hpdcache_req_issuer.sv
// Requester-side issuer for one HPDcache core port: two-cycle request protocol, TID allocation, response filter.
// Latency: request issued 1 cycle after the client handshake; tag/PMA/abort 1 cycle after grant; responses pass through combinationally.
// Backpressure: client stalls while the issued request awaits grant or when need_rsp finds no free TID; no response backpressure.
//
// Ports: up_req_* client request side (abort sampled the cycle after grant);
// core_req_* towards the arbiter; core_rsp_* from the cache; up_rsp_* filtered
// to this SID; outstanding_o busy TID count; spurious_rsp_o own-SID response to a free TID.
module hpdcache_req_issuer
    import hpdcache_pkg::*;
#(
    parameter hpdcache_req_sid_t SID    = '0,
    parameter int unsigned       NTRANS = 4
)(
    input  logic                        clk_i,
    input  logic                        rst_ni,

    input  logic                        up_req_valid_i,
    output logic                        up_req_ready_o,
    input  hpdcache_req_t               up_req_i,
    input  logic                        up_abort_i,
    input  hpdcache_tag_t               up_tag_i,
    input  hpdcache_pma_t               up_pma_i,

    output logic                        core_req_valid_o,
    input  logic                        core_req_ready_i,
    output hpdcache_req_t               core_req_o,
    output logic                        core_req_abort_o,
    output hpdcache_tag_t               core_req_tag_o,
    output hpdcache_pma_t               core_req_pma_o,

    input  logic                        core_rsp_valid_i,
    input  hpdcache_rsp_t               core_rsp_i,
    output logic                        up_rsp_valid_o,
    output hpdcache_rsp_t               up_rsp_o,

    output logic [$clog2(NTRANS+1)-1:0] outstanding_o,
    output logic                        spurious_rsp_o
);

    hpdcache_req_t     req_q;
    hpdcache_req_t     req_d;
    logic              req_vld_q;
    hpdcache_tag_t     pend_tag_q;
    hpdcache_pma_t     pend_pma_q;
    hpdcache_tag_t     tag_q;
    hpdcache_pma_t     pma_q;
    logic              granted_q;

    logic              tid_avail;
    hpdcache_req_tid_t alloc_tid;
    logic              up_hs;
    logic              grant;
    logic              rsp_own;

    assign grant          = req_vld_q & core_req_ready_i;
    assign up_req_ready_o = (!req_vld_q | core_req_ready_i) & (!up_req_i.need_rsp | tid_avail);
    assign up_hs          = up_req_valid_i & up_req_ready_o;
    assign rsp_own        = core_rsp_valid_i & (core_rsp_i.sid == SID);

    always_comb begin
        req_d     = up_req_i;
        req_d.sid = SID;
        req_d.tid = up_req_i.need_rsp ? alloc_tid : '0;
    end

    // Tag/PMA go through a pending stage so that a request loaded on the
    // same edge as a grant cannot overwrite the 2nd-cycle values in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q      <= '0;
            req_vld_q  <= 1'b0;
            pend_tag_q <= '0;
            pend_pma_q <= '0;
            tag_q      <= '0;
            pma_q      <= '0;
            granted_q  <= 1'b0;
        end else begin
            granted_q <= grant;
            if (grant) begin
                tag_q <= pend_tag_q;
                pma_q <= pend_pma_q;
            end
            if (up_hs) begin
                req_q      <= req_d;
                req_vld_q  <= 1'b1;
                pend_tag_q <= up_tag_i;
                pend_pma_q <= up_pma_i;
            end else if (grant) begin
                req_vld_q  <= 1'b0;
            end
        end
    end

    hpdcache_tid_pool #(
        .NTRANS        (NTRANS)
    ) i_tid_pool (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .alloc_i       (up_hs & up_req_i.need_rsp),
        .tid_avail_o   (tid_avail),
        .alloc_tid_o   (alloc_tid),
        .rsp_own_i     (rsp_own),
        .rsp_tid_i     (core_rsp_i.tid),
        .spurious_o    (spurious_rsp_o),
        .outstanding_o (outstanding_o)
    );

    assign core_req_valid_o = req_vld_q;
    assign core_req_o       = req_q;
    assign core_req_abort_o = up_abort_i & granted_q;
    assign core_req_tag_o   = tag_q;
    assign core_req_pma_o   = pma_q;

    assign up_rsp_valid_o   = rsp_own;
    assign up_rsp_o         = core_rsp_i;

endmodule
